spi_flash_bridge: RTL and testbench

Bus-side front end for the SPI flash master (`spi_tx`). It sits between the CPU instruction/data bus and `spi_tx`. After reset it issues the flash release-from-power-down command (0xAB) and waits tRES1. It then converts word reads on the bus into 0x03 read transactions and reorders the received bytes to little-endian. A single-word last-read buffer answers repeated reads without an SPI cycle.

---
 rtl/spi_flash_bridge.sv | 180 ++++++++++++++++++
 tb/tb_spi_flash_bridge.sv | 331 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_bridge.sv
// spi_flash_bridge
// Bus-side front end for the spi_tx flash master. After reset it wakes the
// flash with a release-from-power-down command (0xAB) and waits out tRES1.
// It then turns bus word reads into 0x03 flash reads and returns the data
// little-endian. A one-word buffer keeps the most recent read, so repeating
// that access completes without an SPI transaction.
module spi_flash_bridge #(
  parameter int WAKE_CYCLES = 30,
  parameter int USE_BUF     = 1
) (
  input  logic        ck,
  input  logic        rst_n,
  input  logic        bus_valid,
  input  logic [23:0] bus_addr,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  spi_code,
  output logic [23:0] spi_addr,
  output logic        spi_tx_addr,
  output logic        spi_no_read,
  output logic        spi_req,
  input  logic [31:0] spi_rdata,
  input  logic        spi_ready,
  output logic        busy
);

  localparam logic [7:0] CMD_RES  = 8'hAB;
  localparam logic [7:0] CMD_READ = 8'h03;

  // The counter holds WAKE_CYCLES-1 down to 0.
  localparam int               CNT_W     = (WAKE_CYCLES > 2) ? $clog2(WAKE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] WAKE_LOAD = CNT_W'(WAKE_CYCLES - 32'sd1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1'b1);
  localparam logic [CNT_W-1:0] CNT_ZERO  = CNT_W'(1'b0);
  localparam logic             BUF_ON    = (USE_BUF != 32'sd0);

  typedef enum logic [2:0] {
    ST_WAKE_REQ  = 3'd0,
    ST_WAKE_WAIT = 3'd1,
    ST_WAKE_DLY  = 3'd2,
    ST_IDLE      = 3'd3,
    ST_RD_REQ    = 3'd4,
    ST_RD_WAIT   = 3'd5,
    ST_RESP      = 3'd6,
    ST_GAP       = 3'd7
  } state_t;

  // spi_tx shifts the first received byte into [31:24]; the bus wants it in [7:0].
  function automatic logic [31:0] swap_bytes(input logic [31:0] d);
    return {d[7:0], d[15:8], d[23:16], d[31:24]};
  endfunction

  state_t           state_r;
  logic [CNT_W-1:0] cnt_r;
  logic             busy_r;
  logic             bus_ready_r;
  logic [31:0]      bus_rdata_r;
  logic             spi_req_r;
  logic [7:0]       spi_code_r;
  logic [23:0]      spi_addr_r;
  logic             spi_tx_addr_r;
  logic             spi_no_read_r;
  logic             buf_valid_r;
  logic [21:0]      buf_addr_r;
  logic [31:0]      buf_data_r;
  logic             hit_s;
  logic [31:0]      swapped_s;

  assign swapped_s = swap_bytes(spi_rdata);

  // Buffer hit: the stored word address matches the requested one
  always_comb begin
    hit_s = 1'b0;
    if (BUF_ON && buf_valid_r && (buf_addr_r == bus_addr[23:2])) begin
      hit_s = 1'b1;
    end else begin
      hit_s = 1'b0;
    end
  end

  // Sequencer: wake handshake, read dispatch, buffer update and bus response
  always_ff @(posedge ck or negedge rst_n) begin
    if (!rst_n) begin
      state_r       <= ST_WAKE_REQ;
      cnt_r         <= CNT_ZERO;
      busy_r        <= 1'b1;
      bus_ready_r   <= 1'b0;
      bus_rdata_r   <= 32'h0000_0000;
      spi_req_r     <= 1'b0;
      spi_code_r    <= CMD_RES;
      spi_addr_r    <= 24'h00_0000;
      spi_tx_addr_r <= 1'b0;
      spi_no_read_r <= 1'b1;
      buf_valid_r   <= 1'b0;
      buf_addr_r    <= 22'h00_0000;
      buf_data_r    <= 32'h0000_0000;
    end else begin
      case (state_r)
        ST_WAKE_REQ: begin
          spi_req_r     <= 1'b1;
          spi_code_r    <= CMD_RES;
          spi_tx_addr_r <= 1'b0;
          spi_no_read_r <= 1'b1;
          state_r       <= ST_WAKE_WAIT;
        end
        ST_WAKE_WAIT: begin
          spi_req_r <= 1'b0;
          if (spi_ready) begin
            cnt_r   <= WAKE_LOAD;
            state_r <= ST_WAKE_DLY;
          end
        end
        ST_WAKE_DLY: begin
          if (cnt_r == CNT_ZERO) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r - CNT_ONE;
          end
        end
        ST_IDLE: begin
          if (bus_valid) begin
            if (hit_s) begin
              bus_rdata_r <= buf_data_r;
              bus_ready_r <= 1'b1;
              state_r     <= ST_RESP;
            end else begin
              // Request goes out on the very next cycle; the command fields
              // stay registered until the following request.
              spi_req_r     <= 1'b1;
              spi_code_r    <= CMD_READ;
              spi_addr_r    <= bus_addr & 24'hFF_FFFC;
              spi_tx_addr_r <= 1'b1;
              spi_no_read_r <= 1'b0;
              state_r       <= ST_RD_REQ;
            end
          end
        end
        ST_RD_REQ: begin
          spi_req_r <= 1'b0;
          state_r   <= ST_RD_WAIT;
        end
        ST_RD_WAIT: begin
          if (spi_ready) begin
            bus_rdata_r <= swapped_s;
            bus_ready_r <= 1'b1;
            buf_data_r  <= swapped_s;
            buf_addr_r  <= spi_addr_r[23:2];
            buf_valid_r <= BUF_ON;
            state_r     <= ST_RESP;
          end
        end
        ST_RESP: begin
          bus_ready_r <= 1'b0;
          state_r     <= ST_GAP;
        end
        ST_GAP: begin
          state_r <= ST_IDLE;
        end
        default: begin
          spi_req_r   <= 1'b0;
          bus_ready_r <= 1'b0;
          busy_r      <= 1'b1;
          buf_valid_r <= 1'b0;
          state_r     <= ST_WAKE_REQ;
        end
      endcase
    end
  end

  assign bus_rdata   = bus_rdata_r;
  assign bus_ready   = bus_ready_r;
  assign spi_code    = spi_code_r;
  assign spi_addr    = spi_addr_r;
  assign spi_tx_addr = spi_tx_addr_r;
  assign spi_no_read = spi_no_read_r;
  assign spi_req     = spi_req_r;
  assign busy        = busy_r;

endmodule

// File: tb/tb_spi_flash_bridge.sv
// tb_spi_flash_bridge
// Drives a buffered bridge (dut) and an unbuffered one (dut_b) against small
// spi_tx response models; expected values are hand-computed constants.
module tb_spi_flash_bridge;

  localparam int WAKE   = 30;
  localparam int B_WAKE = 4;

  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst_n;
  logic        bus_valid;
  logic [23:0] bus_addr;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  spi_code;
  logic [23:0] spi_addr;
  logic        spi_tx_addr;
  logic        spi_no_read;
  logic        spi_req;
  logic [31:0] spi_rdata;
  logic        spi_ready;
  logic        busy;

  logic        b_bus_valid;
  logic [23:0] b_bus_addr;
  logic [31:0] b_bus_rdata;
  logic        b_bus_ready;
  logic [7:0]  b_spi_code;
  logic [23:0] b_spi_addr;
  logic        b_spi_tx_addr;
  logic        b_spi_no_read;
  logic        b_spi_req;
  logic [31:0] b_spi_rdata;
  logic        b_spi_ready;
  logic        b_busy;

  spi_flash_bridge #(.WAKE_CYCLES(WAKE), .USE_BUF(1)) dut (
    .ck(ck), .rst_n(rst_n), .bus_valid(bus_valid), .bus_addr(bus_addr),
    .bus_rdata(bus_rdata), .bus_ready(bus_ready), .spi_code(spi_code),
    .spi_addr(spi_addr), .spi_tx_addr(spi_tx_addr), .spi_no_read(spi_no_read),
    .spi_req(spi_req), .spi_rdata(spi_rdata), .spi_ready(spi_ready), .busy(busy)
  );

  spi_flash_bridge #(.WAKE_CYCLES(B_WAKE), .USE_BUF(0)) dut_b (
    .ck(ck), .rst_n(rst_n), .bus_valid(b_bus_valid), .bus_addr(b_bus_addr),
    .bus_rdata(b_bus_rdata), .bus_ready(b_bus_ready), .spi_code(b_spi_code),
    .spi_addr(b_spi_addr), .spi_tx_addr(b_spi_tx_addr), .spi_no_read(b_spi_no_read),
    .spi_req(b_spi_req), .spi_rdata(b_spi_rdata), .spi_ready(b_spi_ready), .busy(b_busy)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // model state (written only by the model process)
  int          mdl_cnt = 0;
  int          req_cnt = 0;
  int          rdy_cnt = 0;
  int          ready_cyc = 0;
  int          last_req_cyc = 0;
  logic [7:0]  last_code = 8'h00;
  logic [23:0] last_addr = 24'h0;
  logic        last_txa = 1'b0;
  logic        last_nr = 1'b0;
  int          spur_seen = 0;
  int          b_cnt = 0;
  int          b_req_cnt = 0;

  // test-side state
  logic [31:0] mdl_data = 32'h0;
  int          spur_cnt = 0;
  int          req_before, start_cyc, got_cyc, rel_cyc, fall_cyc, rdy_before;
  logic        got_ready, width_ok, b_got;
  logic [31:0] got_rdata, b_got_rdata;

  typedef struct {
    logic [23:0] addr;
    logic [31:0] flash;
    logic        hit;
    logic [31:0] rdata;
    logic [23:0] spi_addr;
  } vec_t;
  vec_t vecs[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_bus_ready"},   32'(bus_ready),   32'h0);
    chk({tag, "_bus_rdata"},   bus_rdata,        32'h0);
    chk({tag, "_spi_req"},     32'(spi_req),     32'h0);
    chk({tag, "_spi_code"},    32'(spi_code),    32'hAB);
    chk({tag, "_spi_addr"},    32'(spi_addr),    32'h0);
    chk({tag, "_spi_tx_addr"}, 32'(spi_tx_addr), 32'h0);
    chk({tag, "_spi_no_read"}, 32'(spi_no_read), 32'h1);
    chk({tag, "_busy"},        32'(busy),        32'h1);
  endtask

  // cycle count advances between rising edges so samples at posedge+1 see it stable
  initial forever begin
    @(negedge ck);
    cyc++;
  end

  // spi_tx models: wake reply after 17 cycles, read reply after 129 (dut);
  // fixed 5 cycles for dut_b
  initial begin
    spi_ready   = 1'b0;
    spi_rdata   = 32'h0;
    b_spi_ready = 1'b0;
    b_spi_rdata = 32'h0102_0304;
    forever begin
      @(posedge ck); #1;
      spi_ready   = 1'b0;
      b_spi_ready = 1'b0;
      if (mdl_cnt > 0) begin
        mdl_cnt--;
        if (mdl_cnt == 0) begin
          spi_ready = 1'b1;
          spi_rdata = mdl_data;
          ready_cyc = cyc;
        end
      end
      if (spur_cnt != spur_seen) begin
        spur_seen = spur_cnt;
        spi_ready = 1'b1;
      end
      if (b_cnt > 0) begin
        b_cnt--;
        if (b_cnt == 0) b_spi_ready = 1'b1;
      end
      if (rst_n !== 1'b1) begin
        mdl_cnt = 0;
        b_cnt   = 0;
      end
      if (spi_req === 1'b1) begin
        req_cnt++;
        last_req_cyc = cyc;
        last_code    = spi_code;
        last_addr    = spi_addr;
        last_txa     = spi_tx_addr;
        last_nr      = spi_no_read;
        mdl_cnt      = (spi_code == 8'hAB) ? 17 : 129;
      end
      if (b_spi_req === 1'b1) begin
        b_req_cnt++;
        b_cnt = 5;
      end
      if (bus_ready === 1'b1) rdy_cnt++;
    end
  end

  task automatic do_read(input logic [23:0] addr, input logic [31:0] flash);
    mdl_data   = flash;
    req_before = req_cnt;
    bus_addr   = addr;
    bus_valid  = 1'b1;
    start_cyc  = cyc;
    got_ready  = 1'b0;
    got_rdata  = 32'h0;
    got_cyc    = 0;
    for (int i = 0; i < 400 && !got_ready; i++) begin
      @(posedge ck); #1;
      if (bus_ready === 1'b1) begin
        got_ready = 1'b1;
        got_rdata = bus_rdata;
        got_cyc   = cyc;
      end
    end
    bus_valid = 1'b0;
    @(posedge ck); #1;
    width_ok = (bus_ready === 1'b0);
    @(posedge ck); #1;
  endtask

  task automatic b_read(input logic [23:0] addr);
    b_bus_addr  = addr;
    b_bus_valid = 1'b1;
    b_got       = 1'b0;
    b_got_rdata = 32'h0;
    for (int i = 0; i < 60 && !b_got; i++) begin
      @(posedge ck); #1;
      if (b_bus_ready === 1'b1) begin
        b_got       = 1'b1;
        b_got_rdata = b_bus_rdata;
      end
    end
    b_bus_valid = 1'b0;
    @(posedge ck); #1;
    @(posedge ck); #1;
  endtask

  // wait for busy to drop, recording the cycle it was first seen low
  task automatic wait_awake(input string tag);
    fall_cyc = -1;
    for (int i = 0; i < 300 && fall_cyc < 0; i++) begin
      @(posedge ck); #1;
      if (busy === 1'b0) fall_cyc = cyc;
    end
    chk({tag, "_awake"}, 32'(fall_cyc >= 0), 32'h1);
  endtask

  initial begin
    vecs[0] = '{24'h123456, 32'h1122_3344, 1'b0, 32'h4433_2211, 24'h123454};
    vecs[1] = '{24'h123457, 32'h0000_0000, 1'b1, 32'h4433_2211, 24'h123454};
    vecs[2] = '{24'h123458, 32'hA1B2_C3D4, 1'b0, 32'hD4C3_B2A1, 24'h123458};
    vecs[3] = '{24'h12345B, 32'h0000_0000, 1'b1, 32'hD4C3_B2A1, 24'h123458};
    vecs[4] = '{24'h123454, 32'h0BAD_F00D, 1'b0, 32'h0DF0_AD0B, 24'h123454};
    vecs[5] = '{24'hFFFFFF, 32'hDEAD_BEEF, 1'b0, 32'hEFBE_ADDE, 24'hFFFFFC};
    vecs[6] = '{24'hFFFFFC, 32'h0000_0000, 1'b1, 32'hEFBE_ADDE, 24'hFFFFFC};

    rst_n       = 1'b1;
    bus_valid   = 1'b0;
    bus_addr    = 24'h0;
    b_bus_valid = 1'b0;
    b_bus_addr  = 24'h0;
    #1 rst_n = 1'b0;
    // early request: held from reset onward
    bus_valid = 1'b1;
    bus_addr  = 24'h000100;
    mdl_data  = 32'h5566_7788;
    repeat (3) @(posedge ck);
    #1;
    chk_reset("rst");

    // wake sequence
    req_before = req_cnt;
    rst_n      = 1'b1;
    rel_cyc    = cyc;
    wait_awake("wake");
    chk("wake_req_count", 32'(req_cnt - req_before), 32'd1);
    chk("wake_req_cycle", 32'(last_req_cyc - rel_cyc), 32'd1);
    chk("wake_code",      32'(last_code), 32'hAB);
    chk("wake_tx_addr",   32'(last_txa),  32'h0);
    chk("wake_no_read",   32'(last_nr),   32'h1);
    // spi_ready is sampled one edge after the model raises it; busy drops WAKE edges later
    chk("wake_busy_fall", 32'(fall_cyc - ready_cyc), 32'(WAKE + 1));
    chk("early_no_ready", 32'(rdy_cnt), 32'd0);

    // the held request is now served
    got_ready = 1'b0;
    for (int i = 0; i < 300 && !got_ready; i++) begin
      @(posedge ck); #1;
      if (bus_ready === 1'b1) begin
        got_ready = 1'b1;
        got_rdata = bus_rdata;
      end
    end
    bus_valid = 1'b0;
    repeat (3) @(posedge ck);
    #1;
    chk("early_ready",    32'(got_ready), 32'h1);
    chk("early_rdata",    got_rdata, 32'h8877_6655);
    chk("early_one_read", 32'(req_cnt - req_before), 32'd2);
    chk("early_code",     32'(last_code), 32'h03);
    chk("early_spi_addr", 32'(last_addr), 32'h000100);

    // table-driven reads
    for (int v = 0; v < 7; v++) begin
      do_read(vecs[v].addr, vecs[v].flash);
      chk($sformatf("v%0d_ready", v), 32'(got_ready), 32'h1);
      chk($sformatf("v%0d_rdata", v), got_rdata, vecs[v].rdata);
      chk($sformatf("v%0d_width", v), 32'(width_ok), 32'h1);
      chk($sformatf("v%0d_spi_reqs", v), 32'(req_cnt - req_before), vecs[v].hit ? 32'd0 : 32'd1);
      if (vecs[v].hit) begin
        chk($sformatf("v%0d_hit_lat", v), 32'(got_cyc - start_cyc), 32'd1);
      end else begin
        chk($sformatf("v%0d_req_lat", v), 32'(last_req_cyc - start_cyc), 32'd1);
        chk($sformatf("v%0d_rdy_lat", v), 32'(got_cyc - ready_cyc), 32'd1);
        chk($sformatf("v%0d_spi_addr", v), 32'(last_addr), 32'(vecs[v].spi_addr));
        chk($sformatf("v%0d_code", v), 32'(last_code), 32'h03);
        chk($sformatf("v%0d_txa_nr", v), {30'd0, last_txa, last_nr}, 32'h2);
      end
    end

    // spurious spi_ready in IDLE
    rdy_before = rdy_cnt;
    req_before = req_cnt;
    spur_cnt++;
    repeat (6) @(posedge ck);
    #1;
    chk("spur_no_ready", 32'(rdy_cnt - rdy_before), 32'd0);
    chk("spur_no_req",   32'(req_cnt - req_before), 32'd0);
    do_read(24'hFFFFFD, 32'h0);
    chk("spur_hit_lat",   32'(got_cyc - start_cyc), 32'd1);
    chk("spur_hit_rdata", got_rdata, 32'hEFBE_ADDE);

    // unbuffered instance: every read goes to SPI
    for (int k = 0; k < 2; k++) begin
      req_before = b_req_cnt;
      b_read(24'h000040);
      chk($sformatf("nobuf%0d_ready", k), 32'(b_got), 32'h1);
      chk($sformatf("nobuf%0d_rdata", k), b_got_rdata, 32'h0403_0201);
      chk($sformatf("nobuf%0d_req", k),   32'(b_req_cnt - req_before), 32'd1);
    end

    // reset 50 cycles into a read, then the buffered word must miss
    mdl_data  = 32'h1357_9BDF;
    bus_addr  = 24'h000200;
    bus_valid = 1'b1;
    repeat (50) @(posedge ck);
    #1;
    rst_n = 1'b0;
    #1;
    chk_reset("midrst");
    bus_valid = 1'b0;
    repeat (2) @(posedge ck);
    #1;
    req_before = req_cnt;
    rst_n      = 1'b1;
    wait_awake("rewake");
    chk("rewake_req",  32'(req_cnt - req_before), 32'd1);
    chk("rewake_code", 32'(last_code), 32'hAB);
    @(posedge ck); #1;
    do_read(24'hFFFFFC, 32'hCAFE_F00D);
    chk("postrst_miss",  32'(req_cnt - req_before), 32'd1);
    chk("postrst_rdata", got_rdata, 32'h0DF0_FECA);
    chk("postrst_addr",  32'(last_addr), 32'hFFFFFC);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
